fetch_stage: RTL and testbench

Instruction fetch stage: owns the fetch PC, issues one instruction-memory request at a time over a ready/valid handshake, and presents the returned instruction plus its PC to the IF/ID pipeline register. It sits directly upstream of the IF/ID buffer. It honours the hazard unit's stall and the EX-stage redirect (taken branch/jump), discarding any in-flight response made stale by a redirect.

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time
// and presents the returned instruction plus its PC to the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_IF,
    output logic [31:0] pc_in,
    output logic        valid_IF,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic        drop, drop_n;
    logic        valid_n;
    logic [31:0] instr_n;
    logic [31:0] pc_in_n;
    logic        misalign_n;

    assign imem_req  = (state == S_REQ);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            fetch_pc       <= RESET_PC;
            drop           <= 1'b0;
            valid_IF       <= 1'b0;
            instruction_IF <= NOP_INSTR;
            pc_in          <= '0;
            misalign       <= 1'b0;
        end else begin
            state          <= state_n;
            fetch_pc       <= fetch_pc_n;
            drop           <= drop_n;
            valid_IF       <= valid_n;
            instruction_IF <= instr_n;
            pc_in          <= pc_in_n;
            misalign       <= misalign_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        valid_n    = valid_IF;
        instr_n    = instruction_IF;
        pc_in_n    = pc_in;
        misalign_n = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over stall; an already-accepted request must be drained as stale
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            valid_n    = 1'b0;
            instr_n    = NOP_INSTR;
            misalign_n = |redirect_pc[1:0];
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        state_n = S_WAIT;
                        drop_n  = 1'b1;
                    end else begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        state_n = S_WAIT;
                        drop_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = S_REQ;
                    drop_n  = 1'b0;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ: begin
                    if (imem_ready) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = S_REQ;
                        end else begin
                            instr_n    = imem_rdata;
                            pc_in_n    = fetch_pc;
                            valid_n    = 1'b1;
                            fetch_pc_n = fetch_pc + 32'd4;
                            state_n    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        valid_n = 1'b0;
                        instr_n = NOP_INSTR;
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level model of the fetch
// stream plus a simple latency-randomised instruction memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_IF;
    logic [31:0] pc_in;
    logic        valid_IF;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    // model: outstanding request, stale flag, held instruction
    logic        m_started, m_busy, m_stale, m_hold, m_mis;
    logic [31:0] m_pc, m_instr, m_pcin;

    // memory
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] key;
    int          lat_lo, lat_hi;
    int          acc_cnt;
    int          a0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instruction_IF(instruction_IF),
        .pc_in         (pc_in),
        .valid_IF      (valid_IF),
        .misalign      (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_imem_req", 32'(imem_req), 32'(m_started && !m_busy && !m_hold));
        chk("model_imem_addr", imem_addr, m_pc);
        chk("model_valid_IF", 32'(valid_IF), 32'(m_hold));
        chk("model_instruction_IF", instruction_IF, m_hold ? m_instr : NOP);
        chk("model_pc_in", pc_in, m_pcin);
        chk("model_misalign", 32'(misalign), 32'(m_mis));
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_mis = 1'b0;
        m_pc = 32'h0; m_instr = NOP; m_pcin = 32'h0;
        pend = 1'b0; cnt = 0;
    endtask

    // Called at a negedge; drives one cycle of inputs, checks, advances to next negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        logic        acc, resp, rv;
        logic [31:0] rd, a;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rp;
        imem_ready     = rdy;
        rv             = pend && (cnt == 0);
        imem_rvalid    = rv;
        imem_rdata     = rv ? (paddr ^ key) : $urandom;
        #1;
        compare_model();
        acc  = m_started && !m_busy && !m_hold && rdy;
        resp = m_busy && rv;
        rd   = imem_rdata;
        a    = imem_addr;
        @(posedge clk);
        m_mis     = r && (rp[1:0] != 2'b00);
        m_started = 1'b1;
        if (r) begin
            m_pc   = {rp[31:2], 2'b00};
            m_hold = 1'b0;
            if (acc) begin
                m_busy = 1'b1; m_stale = 1'b1;
            end else if (resp) begin
                m_busy = 1'b0; m_stale = 1'b0;
            end else if (m_busy) begin
                m_stale = 1'b1;
            end
        end else if (acc) begin
            m_busy = 1'b1;
        end else if (resp) begin
            m_busy = 1'b0;
            if (m_stale) m_stale = 1'b0;
            else begin
                m_hold  = 1'b1;
                m_instr = rd;
                m_pcin  = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end else if (m_hold && !s) begin
            m_hold = 1'b0;
        end
        if (rv) pend = 1'b0;
        else if (pend) cnt--;
        if (acc) begin
            pend  = 1'b1;
            paddr = a;
            cnt   = int'($urandom_range(lat_hi, lat_lo));
            acc_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_valid_IF", 32'(valid_IF), 32'h0);
        chk("rst_instruction_IF", instruction_IF, 32'h13);
        chk("rst_pc_in", pc_in, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_valid(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (valid_IF) break;
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk(name, 32'(valid_IF), 32'h1);
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        acc_cnt = 0; key = '0; lat_lo = 0; lat_hi = 0;
        model_reset();
        #2;
        do_reset();

        // zero-wait memory returning address as data
        chk("c0_req", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c1_req", 32'(imem_req), 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c2_req", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c3_valid", 32'(valid_IF), 32'h1);
        chk("c3_pc_in", pc_in, 32'h0);
        chk("c3_instr", instruction_IF, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c4_req", 32'(imem_req), 32'h1);
        chk("c4_addr", imem_addr, 32'h4);
        chk("c4_valid", 32'(valid_IF), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c6_pc_in", pc_in, 32'h4);
        chk("c6_instr", instruction_IF, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c7_addr", imem_addr, 32'h8);

        // stall held in HOLD
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk("stall_valid", 32'(valid_IF), 32'h1);
            chk("stall_pc_in", pc_in, 32'h8);
            chk("stall_instr", instruction_IF, 32'h8);
            chk("stall_req", 32'(imem_req), 32'h0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("unstall_req", 32'(imem_req), 32'h1);
        chk("unstall_addr", imem_addr, 32'hC);

        // redirect while WAIT, response two cycles later
        lat_lo = 2; lat_hi = 2;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) break;
            chk("stale_valid", 32'(valid_IF), 32'h0);
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("redir_wait_req", 32'(imem_req), 32'h1);
        chk("redir_wait_addr", imem_addr, 32'h100);
        run_until_valid(10, "redir_wait_timeout");
        chk("redir_wait_pc_in", pc_in, 32'h100);
        chk("redir_wait_instr", instruction_IF, 32'h100);

        // redirect in same cycle as imem_ready
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        a0 = acc_cnt;
        run_until_valid(10, "redir_ready_timeout");
        chk("redir_ready_nreq", 32'(acc_cnt - a0), 32'h1);
        chk("redir_ready_pc_in", pc_in, 32'h200);

        // redirect in same cycle as imem_rvalid
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        a0 = acc_cnt;
        run_until_valid(10, "redir_rvalid_timeout");
        chk("redir_rvalid_nreq", 32'(acc_cnt - a0), 32'h1);
        chk("redir_rvalid_pc_in", pc_in, 32'h200);

        // misaligned redirect under stall
        step(1'b1, 1'b1, 32'h103, 1'b1);
        chk("mis_pulse", 32'(misalign), 32'h1);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_req", 32'(imem_req), 32'h1);
        chk("mis_valid", 32'(valid_IF), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("mis_clear", 32'(misalign), 32'h0);
        run_until_valid(10, "mis_timeout");
        chk("mis_pc_in", pc_in, 32'h100);

        // PC wrap, then reset mid-WAIT
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        run_until_valid(10, "wrap_timeout");
        chk("wrap_pc_in", pc_in, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_req", 32'(imem_req), 32'h1);
        chk("wrap_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        do_reset();
        chk("rst2_c0_req", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst2_c1_req", 32'(imem_req), 32'h1);
        chk("rst2_c1_addr", imem_addr, 32'h0);

        // randomized traffic
        lat_lo = 0; lat_hi = 3;
        key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom, ($urandom % 10) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
